sram_req_arbiter: RTL and testbench

- Sits directly upstream of the SRAM port wrapper and drives its io_sram_* request interface.
- Serves two masters with valid/ready request channels and pipelined response channels:
  - instruction-fetch master (ib): read-only, multi-beat bursts.
  - data master (db): single-beat read or byte-masked write.
- Arbitrates between the masters, expands bursts into consecutive word requests, and returns read data with a fixed latency.

---
 rtl/sram_req_arbiter_if.sv | 50 +++++
 rtl/sram_req_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_arbiter_if.sv
// Request/response bundle between the ib/db masters, the arbiter and the SRAM port wrapper.
// The slave modport is the arbiter's view; master is the view of whoever drives the requests.
`timescale 1ns/1ps

interface sram_req_arbiter_if #(
  parameter int LEN_W   = 3,
  parameter int SRAM_AW = 20
);
  logic               ib_req_valid;
  logic               ib_req_ready;
  logic [31:0]        ib_req_addr;
  logic [LEN_W-1:0]   ib_req_len;
  logic               ib_resp_valid;
  logic [31:0]        ib_resp_data;
  logic               ib_resp_last;

  logic               db_req_valid;
  logic               db_req_ready;
  logic [31:0]        db_req_addr;
  logic               db_req_we;
  logic [31:0]        db_req_wdata;
  logic [3:0]         db_req_wstrb;
  logic               db_resp_valid;
  logic [31:0]        db_resp_data;

  logic               io_sram_en;
  logic               io_sram_we;
  logic [SRAM_AW-1:0] io_sram_addr;
  logic [31:0]        io_sram_din;
  logic [3:0]         io_sram_wmask;
  logic [31:0]        io_sram_dout;

  modport slave (
    input  ib_req_valid, ib_req_addr, ib_req_len,
    output ib_req_ready, ib_resp_valid, ib_resp_data, ib_resp_last,
    input  db_req_valid, db_req_addr, db_req_we, db_req_wdata, db_req_wstrb,
    output db_req_ready, db_resp_valid, db_resp_data,
    output io_sram_en, io_sram_we, io_sram_addr, io_sram_din, io_sram_wmask,
    input  io_sram_dout
  );

  modport master (
    output ib_req_valid, ib_req_addr, ib_req_len,
    input  ib_req_ready, ib_resp_valid, ib_resp_data, ib_resp_last,
    output db_req_valid, db_req_addr, db_req_we, db_req_wdata, db_req_wstrb,
    input  db_req_ready, db_resp_valid, db_resp_data,
    input  io_sram_en, io_sram_we, io_sram_addr, io_sram_din, io_sram_wmask,
    output io_sram_dout
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter between an instruction-fetch burst master and a data master in front
// of a single SRAM port; bursts are expanded into word requests, read data returns two cycles after issue.
`timescale 1ns/1ps

module sram_req_arbiter #(
  parameter int LEN_W   = 3,
  parameter int SRAM_AW = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_req_arbiter_if.slave    bus
);

  typedef enum logic {IDLE, IB_BURST} state_e;
  typedef enum logic {GRANT_IB, GRANT_DB} grant_e;

  state_e             state_q, state_d;
  grant_e             last_grant_q, last_grant_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [SRAM_AW-1:0] burst_addr_q, burst_addr_d;

  logic               iss_valid_q, iss_valid_d;
  logic               iss_db_q, iss_db_d;
  logic               iss_we_q, iss_we_d;
  logic               iss_last_q, iss_last_d;

  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_db_q, rsp_db_d;
  logic               rsp_last_q, rsp_last_d;
  logic [31:0]        rsp_data_q, rsp_data_d;

  logic [SRAM_AW-1:0] ib_word;
  logic [SRAM_AW-1:0] db_word;
  logic               grant_ib;
  logic               grant_db;

  logic               ib_ready;
  logic               db_ready;
  logic               sram_en;
  logic               sram_we;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_din;
  logic [3:0]         sram_wmask;

  logic               ib_resp_valid;
  logic               db_resp_valid;

  logic               unused_addr_bits;

  assign ib_word = bus.ib_req_addr[SRAM_AW+1:2];
  assign db_word = bus.db_req_addr[SRAM_AW+1:2];
  assign unused_addr_bits = ^{bus.ib_req_addr[31:SRAM_AW+2], bus.ib_req_addr[1:0],
                              bus.db_req_addr[31:SRAM_AW+2], bus.db_req_addr[1:0]};

  // With both masters valid the one that did not win last time goes first.
  assign grant_db = (state_q == IDLE) && bus.db_req_valid &&
                    (!bus.ib_req_valid || (last_grant_q == GRANT_IB));
  assign grant_ib = (state_q == IDLE) && bus.ib_req_valid && !grant_db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_IB;
      remaining_q  <= '0;
      burst_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      remaining_q  <= remaining_d;
      burst_addr_q <= burst_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    remaining_d  = remaining_q;
    burst_addr_d = burst_addr_q;
    ib_ready     = 1'b0;
    db_ready     = 1'b0;
    sram_en      = 1'b0;
    sram_we      = 1'b0;
    sram_addr    = '0;
    sram_din     = '0;
    sram_wmask   = '0;
    iss_valid_d  = 1'b0;
    iss_db_d     = 1'b0;
    iss_we_d     = 1'b0;
    iss_last_d   = 1'b0;

    case (state_q)
      IDLE: begin
        ib_ready = !(bus.ib_req_valid && grant_db);
        db_ready = !(bus.db_req_valid && grant_ib);
        if (grant_ib) begin
          sram_en      = 1'b1;
          sram_addr    = ib_word;
          last_grant_d = GRANT_IB;
          iss_valid_d  = 1'b1;
          iss_last_d   = (bus.ib_req_len == '0);
          if (bus.ib_req_len != '0) begin
            state_d      = IB_BURST;
            remaining_d  = bus.ib_req_len;
            burst_addr_d = ib_word + SRAM_AW'(1);
          end
        end else if (grant_db) begin
          sram_en      = 1'b1;
          sram_we      = bus.db_req_we;
          sram_addr    = db_word;
          last_grant_d = GRANT_DB;
          iss_valid_d  = 1'b1;
          iss_db_d     = 1'b1;
          iss_we_d     = bus.db_req_we;
          if (bus.db_req_we) begin
            sram_din   = bus.db_req_wdata;
            sram_wmask = bus.db_req_wstrb;
          end
        end
      end

      IB_BURST: begin
        sram_en      = 1'b1;
        sram_addr    = burst_addr_q;
        iss_valid_d  = 1'b1;
        burst_addr_d = burst_addr_q + SRAM_AW'(1);
        remaining_d  = remaining_q - LEN_W'(1);
        if (remaining_q == LEN_W'(1)) begin
          iss_last_d = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Nothing may reach the SRAM or be handshaken while reset is asserted.
    if (!rst_n) begin
      ib_ready = 1'b0;
      db_ready = 1'b0;
      sram_en  = 1'b0;
      sram_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_db_q    <= 1'b0;
      iss_we_q    <= 1'b0;
      iss_last_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_db_q    <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_db_q    <= iss_db_d;
      iss_we_q    <= iss_we_d;
      iss_last_q  <= iss_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_db_q    <= rsp_db_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // SRAM read data is valid the cycle after issue; writes acknowledge with zero data.
  always_comb begin
    rsp_valid_d = iss_valid_q;
    rsp_db_d    = iss_db_q;
    rsp_last_d  = iss_last_q;
    rsp_data_d  = '0;
    if (iss_valid_q && !iss_we_q) begin
      rsp_data_d = bus.io_sram_dout;
    end
  end

  assign ib_resp_valid = rsp_valid_q && !rsp_db_q;
  assign db_resp_valid = rsp_valid_q && rsp_db_q;

  assign bus.ib_req_ready  = ib_ready;
  assign bus.db_req_ready  = db_ready;
  assign bus.io_sram_en    = sram_en;
  assign bus.io_sram_we    = sram_we;
  assign bus.io_sram_addr  = sram_addr;
  assign bus.io_sram_din   = sram_din;
  assign bus.io_sram_wmask = sram_wmask;

  assign bus.ib_resp_valid = ib_resp_valid;
  assign bus.ib_resp_data  = ib_resp_valid ? rsp_data_q : 32'h0;
  assign bus.ib_resp_last  = ib_resp_valid && rsp_last_q;
  assign bus.db_resp_valid = db_resp_valid;
  assign bus.db_resp_data  = db_resp_valid ? rsp_data_q : 32'h0;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: a vector table walked cycle by cycle from reset,
// then hand-written sequences for reset mid-burst and round-robin right after reset.
`timescale 1ns/1ps

module tb_sram_req_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sram_req_arbiter_if #(.LEN_W(3), .SRAM_AW(20)) bus ();

  sram_req_arbiter #(.LEN_W(3), .SRAM_AW(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: read data is a known function of the word address, garbage otherwise.
  function automatic logic [31:0] sram_data(input logic [19:0] a);
    if (a == 20'h00008) return 32'h12345678;
    return {12'hC0D, a};
  endfunction

  always @(posedge clk) begin
    if (bus.io_sram_en && !bus.io_sram_we) bus.io_sram_dout <= sram_data(bus.io_sram_addr);
    else                                   bus.io_sram_dout <= 32'hBAD0BAD0;
  end

  typedef struct {
    string       name;
    logic        ib_v;
    logic [31:0] ib_addr;
    logic [2:0]  ib_len;
    logic        db_v;
    logic        db_we;
    logic [31:0] db_addr;
    logic [31:0] db_wdata;
    logic [3:0]  db_wstrb;
    logic        x_ib_rdy;
    logic        x_db_rdy;
    logic        x_en;
    logic        x_we;
    logic [19:0] x_addr;
    logic [31:0] x_din;
    logic [3:0]  x_wmask;
    logic        x_ib_rv;
    logic        x_ib_last;
    logic [31:0] x_ib_data;
    logic        x_db_rv;
    logic [31:0] x_db_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t vin(input string n, input logic ibv, input logic [31:0] iba,
                               input logic [2:0] ibl, input logic dbv, input logic dbwe,
                               input logic [31:0] dba, input logic [31:0] dbwd,
                               input logic [3:0] dbws);
    vec_t r;
    r.name = n;
    r.ib_v = ibv; r.ib_addr = iba; r.ib_len = ibl;
    r.db_v = dbv; r.db_we = dbwe; r.db_addr = dba; r.db_wdata = dbwd; r.db_wstrb = dbws;
    r.x_ib_rdy = 1'b1; r.x_db_rdy = 1'b1; r.x_en = 1'b0; r.x_we = 1'b0;
    r.x_addr = '0; r.x_din = '0; r.x_wmask = '0;
    r.x_ib_rv = 1'b0; r.x_ib_last = 1'b0; r.x_ib_data = '0;
    r.x_db_rv = 1'b0; r.x_db_data = '0;
    return r;
  endfunction

  function automatic vec_t idle(input string n);
    return vin(n, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endfunction

  function automatic vec_t dbr(input string n, input logic [31:0] a);
    return vin(n, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, a, 32'hFFFFFFFF, 4'hF);
  endfunction

  function automatic vec_t dbw(input string n, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
    return vin(n, 1'b0, 32'h0, 3'd0, 1'b1, 1'b1, a, d, s);
  endfunction

  function automatic vec_t xiss(input vec_t v, input logic ibr, input logic dbr_i, input logic we,
                                input logic [19:0] a, input logic [31:0] d, input logic [3:0] m);
    vec_t r;
    r = v;
    r.x_ib_rdy = ibr; r.x_db_rdy = dbr_i; r.x_en = 1'b1; r.x_we = we;
    r.x_addr = a; r.x_din = d; r.x_wmask = m;
    return r;
  endfunction

  function automatic vec_t xib(input vec_t v, input logic [31:0] d, input logic last);
    vec_t r;
    r = v;
    r.x_ib_rv = 1'b1; r.x_ib_data = d; r.x_ib_last = last;
    return r;
  endfunction

  function automatic vec_t xdb(input vec_t v, input logic [31:0] d);
    vec_t r;
    r = v;
    r.x_db_rv = 1'b1; r.x_db_data = d;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.ib_req_valid = v.ib_v;
    bus.ib_req_addr  = v.ib_addr;
    bus.ib_req_len   = v.ib_len;
    bus.db_req_valid = v.db_v;
    bus.db_req_we    = v.db_we;
    bus.db_req_addr  = v.db_addr;
    bus.db_req_wdata = v.db_wdata;
    bus.db_req_wstrb = v.db_wstrb;
  endtask

  task automatic checkRow(input vec_t v);
    checkOutput({v.name, ".ib_ready"}, 32'(bus.ib_req_ready), 32'(v.x_ib_rdy));
    checkOutput({v.name, ".db_ready"}, 32'(bus.db_req_ready), 32'(v.x_db_rdy));
    checkOutput({v.name, ".en"},       32'(bus.io_sram_en),   32'(v.x_en));
    checkOutput({v.name, ".we"},       32'(bus.io_sram_we),   32'(v.x_we));
    if (v.x_en) begin
      checkOutput({v.name, ".addr"},  32'(bus.io_sram_addr),  32'(v.x_addr));
      checkOutput({v.name, ".din"},   bus.io_sram_din,        v.x_din);
      checkOutput({v.name, ".wmask"}, 32'(bus.io_sram_wmask), 32'(v.x_wmask));
    end
    checkOutput({v.name, ".ib_rv"},   32'(bus.ib_resp_valid), 32'(v.x_ib_rv));
    checkOutput({v.name, ".ib_last"}, 32'(bus.ib_resp_last),  32'(v.x_ib_last));
    if (v.x_ib_rv) checkOutput({v.name, ".ib_data"}, bus.ib_resp_data, v.x_ib_data);
    checkOutput({v.name, ".db_rv"},   32'(bus.db_resp_valid), 32'(v.x_db_rv));
    if (v.x_db_rv) checkOutput({v.name, ".db_data"}, bus.db_resp_data, v.x_db_data);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;

    // Single-beat traffic, write/read turnaround, arbitration and a wrapping burst.
    tbl.push_back(xiss(dbw("wr1", 32'h10, 32'hDEADBEEF, 4'b0011), 1, 1, 1, 20'h00004, 32'hDEADBEEF, 4'b0011));
    tbl.push_back(idle("wr1_t1"));
    tbl.push_back(xdb(idle("wr1_ack"), 32'h0));
    tbl.push_back(xiss(dbr("rd2", 32'h20), 1, 1, 0, 20'h00008, 32'h0, 4'h0));
    tbl.push_back(idle("rd2_t1"));
    tbl.push_back(xdb(idle("rd2_resp"), 32'h12345678));
    tbl.push_back(idle("rd2_once"));
    tbl.push_back(xiss(dbr("rd5a", 32'h4), 1, 1, 0, 20'h00001, 32'h0, 4'h0));
    tbl.push_back(xiss(dbr("rd5b", 32'h8), 1, 1, 0, 20'h00002, 32'h0, 4'h0));
    tbl.push_back(xdb(xiss(dbr("rd5c", 32'hC), 1, 1, 0, 20'h00003, 32'h0, 4'h0), 32'hC0D00001));
    tbl.push_back(xdb(idle("rd5_r2"), 32'hC0D00002));
    tbl.push_back(xdb(idle("rd5_r3"), 32'hC0D00003));
    tbl.push_back(idle("rd5_end"));
    tbl.push_back(xiss(dbw("wr_rd_w", 32'h40, 32'h11112222, 4'b1100), 1, 1, 1, 20'h00010, 32'h11112222, 4'b1100));
    tbl.push_back(xiss(dbr("wr_rd_r", 32'h44), 1, 1, 0, 20'h00011, 32'h0, 4'h0));
    tbl.push_back(xdb(xiss(dbw("rd_wr_w", 32'h48, 32'h33334444, 4'b0001), 1, 1, 1, 20'h00012, 32'h33334444, 4'b0001), 32'h0));
    tbl.push_back(xdb(idle("rd_wr_r1"), 32'hC0D00011));
    tbl.push_back(xdb(idle("rd_wr_r2"), 32'h0));
    tbl.push_back(idle("rd_wr_end"));
    tbl.push_back(xiss(vin("arb1", 1, 32'h100, 3'd0, 1, 0, 32'h200, 32'h0, 4'h0), 1, 0, 0, 20'h00040, 32'h0, 4'h0));
    tbl.push_back(xiss(vin("arb2", 1, 32'h104, 3'd0, 1, 0, 32'h200, 32'h0, 4'h0), 0, 1, 0, 20'h00080, 32'h0, 4'h0));
    tbl.push_back(xib(xiss(vin("arb3", 1, 32'h104, 3'd0, 1, 0, 32'h204, 32'h0, 4'h0), 1, 0, 0, 20'h00041, 32'h0, 4'h0), 32'hC0D00040, 1));
    tbl.push_back(xdb(xiss(dbr("arb4", 32'h204), 1, 1, 0, 20'h00081, 32'h0, 4'h0), 32'hC0D00080));
    tbl.push_back(xib(idle("arb_r3"), 32'hC0D00041, 1));
    tbl.push_back(xdb(idle("arb_r4"), 32'hC0D00081));
    tbl.push_back(xiss(vin("bst0", 1, 32'h003FFFF8, 3'd3, 0, 0, 32'h0, 32'h0, 4'h0), 1, 1, 0, 20'hFFFFE, 32'h0, 4'h0));
    tbl.push_back(xiss(dbr("bst1", 32'h300), 0, 0, 0, 20'hFFFFF, 32'h0, 4'h0));
    tbl.push_back(xib(xiss(dbr("bst2", 32'h300), 0, 0, 0, 20'h00000, 32'h0, 4'h0), 32'hC0DFFFFE, 0));
    tbl.push_back(xib(xiss(dbr("bst3", 32'h300), 0, 0, 0, 20'h00001, 32'h0, 4'h0), 32'hC0DFFFFF, 0));
    tbl.push_back(xib(xiss(dbr("bst_db", 32'h300), 1, 1, 0, 20'h000C0, 32'h0, 4'h0), 32'hC0D00000, 0));
    tbl.push_back(xib(idle("bst_last"), 32'hC0D00001, 1));
    tbl.push_back(xdb(idle("bst_dbr"), 32'hC0D000C0));
    tbl.push_back(idle("bst_end"));

    // Reset state, with a pending data request that must not reach the SRAM.
    rst_n = 1'b0;
    applyStimulus(dbr("rst", 32'h20));
    #2;
    checkOutput("rst.en",      32'(bus.io_sram_en),    32'h0);
    checkOutput("rst.ib_rv",   32'(bus.ib_resp_valid), 32'h0);
    checkOutput("rst.db_rv",   32'(bus.db_resp_valid), 32'h0);
    checkOutput("rst.ib_last", 32'(bus.ib_resp_last),  32'h0);
    checkOutput("rst.ib_data", bus.ib_resp_data,       32'h0);
    checkOutput("rst.db_data", bus.db_resp_data,       32'h0);
    applyStimulus(idle("rst_idle"));
    nextCycle();
    nextCycle();
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkRow(tbl[i]);
      nextCycle();
    end

    // Reset asserted while beat 2 of a 4-beat burst is on the SRAM port.
    applyStimulus(vin("rb0", 1, 32'h1000, 3'd3, 0, 0, 32'h0, 32'h0, 4'h0));
    @(negedge clk);
    checkOutput("rb0.en",   32'(bus.io_sram_en),   32'h1);
    checkOutput("rb0.addr", 32'(bus.io_sram_addr), 32'h400);
    nextCycle();
    applyStimulus(idle("rb1"));
    #1;
    checkOutput("rb1.en",   32'(bus.io_sram_en),   32'h1);
    checkOutput("rb1.addr", 32'(bus.io_sram_addr), 32'h401);
    rst_n = 1'b0;
    #1;
    checkOutput("rb_rst.en",    32'(bus.io_sram_en),    32'h0);
    checkOutput("rb_rst.ib_rv", 32'(bus.ib_resp_valid), 32'h0);
    checkOutput("rb_rst.db_rv", 32'(bus.db_resp_valid), 32'h0);
    nextCycle();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rb_post%0d.ib_ready", c), 32'(bus.ib_req_ready),  32'h1);
      checkOutput($sformatf("rb_post%0d.db_ready", c), 32'(bus.db_req_ready),  32'h1);
      checkOutput($sformatf("rb_post%0d.en", c),       32'(bus.io_sram_en),    32'h0);
      checkOutput($sformatf("rb_post%0d.ib_rv", c),    32'(bus.ib_resp_valid), 32'h0);
      checkOutput($sformatf("rb_post%0d.db_rv", c),    32'(bus.db_resp_valid), 32'h0);
      nextCycle();
    end

    // Both masters held valid straight after reset: db, ib, db, then the leftover ib.
    applyStimulus(vin("rr1", 1, 32'h2000, 3'd0, 1, 0, 32'h3000, 32'h0, 4'h0));
    @(negedge clk);
    checkOutput("rr1.ib_ready", 32'(bus.ib_req_ready), 32'h0);
    checkOutput("rr1.db_ready", 32'(bus.db_req_ready), 32'h1);
    checkOutput("rr1.addr",     32'(bus.io_sram_addr), 32'hC00);
    nextCycle();
    applyStimulus(vin("rr2", 1, 32'h2000, 3'd0, 1, 0, 32'h3004, 32'h0, 4'h0));
    @(negedge clk);
    checkOutput("rr2.ib_ready", 32'(bus.ib_req_ready), 32'h1);
    checkOutput("rr2.db_ready", 32'(bus.db_req_ready), 32'h0);
    checkOutput("rr2.addr",     32'(bus.io_sram_addr), 32'h800);
    nextCycle();
    applyStimulus(vin("rr3", 1, 32'h2004, 3'd0, 1, 0, 32'h3004, 32'h0, 4'h0));
    @(negedge clk);
    checkOutput("rr3.ib_ready", 32'(bus.ib_req_ready),  32'h0);
    checkOutput("rr3.db_ready", 32'(bus.db_req_ready),  32'h1);
    checkOutput("rr3.addr",     32'(bus.io_sram_addr),  32'hC01);
    checkOutput("rr3.db_rv",    32'(bus.db_resp_valid), 32'h1);
    checkOutput("rr3.db_data",  bus.db_resp_data,       32'hC0D00C00);
    checkOutput("rr3.ib_rv",    32'(bus.ib_resp_valid), 32'h0);
    nextCycle();
    applyStimulus(vin("rr4", 1, 32'h2004, 3'd0, 0, 0, 32'h0, 32'h0, 4'h0));
    @(negedge clk);
    checkOutput("rr4.ib_ready", 32'(bus.ib_req_ready),  32'h1);
    checkOutput("rr4.addr",     32'(bus.io_sram_addr),  32'h801);
    checkOutput("rr4.ib_rv",    32'(bus.ib_resp_valid), 32'h1);
    checkOutput("rr4.ib_data",  bus.ib_resp_data,       32'hC0D00800);
    checkOutput("rr4.ib_last",  32'(bus.ib_resp_last),  32'h1);
    checkOutput("rr4.db_rv",    32'(bus.db_resp_valid), 32'h0);
    nextCycle();
    applyStimulus(idle("rr5"));
    @(negedge clk);
    checkOutput("rr5.db_rv",   32'(bus.db_resp_valid), 32'h1);
    checkOutput("rr5.db_data", bus.db_resp_data,       32'hC0D00C01);
    checkOutput("rr5.ib_rv",   32'(bus.ib_resp_valid), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("rr6.ib_rv",   32'(bus.ib_resp_valid), 32'h1);
    checkOutput("rr6.ib_data", bus.ib_resp_data,       32'hC0D00801);
    checkOutput("rr6.db_rv",   32'(bus.db_resp_valid), 32'h0);
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
